// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with a per-register busy
// scoreboard for RAW-hazard stalls between decode and writeback.
//
// Ports
//   clk, reset        : clock; synchronous active-high reset (clears data and busy)
//   a1, a2            : read addresses
//   rd1, rd2          : read data (combinational)
//   busy1, busy2      : pending-write flag of a1/a2 (combinational)
//   a3, di3, we3      : write port; a write also retires the busy bit of a3
//   sa, se            : scoreboard set (newly issued producer destination)
//   flush             : drop all older producers (busy bits), data kept
module register_file_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [XLEN-1:0]   di3,
    input  logic              we3,
    input  logic [ADDR_W-1:0] sa,
    input  logic              se,
    input  logic              flush
);

    localparam int unsigned NREGS  = 1 << ADDR_W;
    localparam int unsigned NPORTS = 2;

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    logic              wr_en_c;
    logic              set_en_c;
    logic [ADDR_W-1:0] raddr_c [NPORTS];
    logic [XLEN-1:0]   rdata_c [NPORTS];
    logic              rbusy_c [NPORTS];

    // Writes and sets aimed at a hard-wired zero register are dropped.
    always_comb begin
        wr_en_c  = we3;
        set_en_c = se;
        if ((ZERO_REG != 0) && (a3 == '0)) begin
            wr_en_c = 1'b0;
        end
        if ((ZERO_REG != 0) && (sa == '0)) begin
            set_en_c = 1'b0;
        end
    end

    // Register array next state.
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en_c) begin
            regs_d[a3] = di3;
        end
    end

    // Scoreboard next state; later assignments take priority: set > clear > flush.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        if (wr_en_c) begin
            busy_d[a3] = 1'b0;
        end
        if (set_en_c) begin
            busy_d[sa] = 1'b1;
        end
    end

    // State registers; reset discards any concurrent write, set or flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign raddr_c[0] = a1;
    assign raddr_c[1] = a2;

    // Read ports: stored value, overridden by a same-cycle write (bypass),
    // overridden again by the zero register.
    always_comb begin
        for (int p = 0; p < int'(NPORTS); p++) begin
            rdata_c[p] = regs_q[raddr_c[p]];
            rbusy_c[p] = busy_q[raddr_c[p]];
            if ((BYPASS != 0) && wr_en_c && (a3 == raddr_c[p])) begin
                rdata_c[p] = di3;
                rbusy_c[p] = 1'b0;
            end
            if ((ZERO_REG != 0) && (raddr_c[p] == '0)) begin
                rdata_c[p] = '0;
                rbusy_c[p] = 1'b0;
            end
        end
    end

    assign rd1   = rdata_c[0];
    assign rd2   = rdata_c[1];
    assign busy1 = rbusy_c[0];
    assign busy2 = rbusy_c[1];

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: four instances (default,
// no-bypass, 64-bit/16-entry, 64-bit/16-entry without zero register).
module tb_register_file_sb;

    logic        clk;
    logic        reset;

    // 32-bit, 32-entry stimulus shared by u0 (bypass) and u1 (no bypass)
    logic [4:0]  a1, a2, a3, sa;
    logic [31:0] di3;
    logic        we3, se, flush;
    logic [31:0] u0_rd1, u0_rd2, u1_rd1, u1_rd2;
    logic        u0_b1, u0_b2, u1_b1, u1_b2;

    // 64-bit, 16-entry stimulus shared by u2 (zero reg) and u3 (no zero reg)
    logic [3:0]  b_a1, b_a2, b_a3, b_sa;
    logic [63:0] b_di3;
    logic        b_we3, b_se, b_flush;
    logic [63:0] u2_rd1, u2_rd2, u3_rd1, u3_rd2;
    logic        u2_b1, u2_b2, u3_b1, u3_b2;

    typedef struct {
        string       tag;
        int unsigned sig;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;

    register_file_sb #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(u0_rd1), .rd2(u0_rd2),
        .busy1(u0_b1), .busy2(u0_b2), .a3(a3), .di3(di3), .we3(we3),
        .sa(sa), .se(se), .flush(flush));

    register_file_sb #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(u1_rd1), .rd2(u1_rd2),
        .busy1(u1_b1), .busy2(u1_b2), .a3(a3), .di3(di3), .we3(we3),
        .sa(sa), .se(se), .flush(flush));

    register_file_sb #(.XLEN(64), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u2 (
        .clk(clk), .reset(reset), .a1(b_a1), .a2(b_a2), .rd1(u2_rd1), .rd2(u2_rd2),
        .busy1(u2_b1), .busy2(u2_b2), .a3(b_a3), .di3(b_di3), .we3(b_we3),
        .sa(b_sa), .se(b_se), .flush(b_flush));

    register_file_sb #(.XLEN(64), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u3 (
        .clk(clk), .reset(reset), .a1(b_a1), .a2(b_a2), .rd1(u3_rd1), .rd2(u3_rd2),
        .busy1(u3_b1), .busy2(u3_b2), .a3(b_a3), .di3(b_di3), .we3(b_we3),
        .sa(b_sa), .se(b_se), .flush(b_flush));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] observe(input int unsigned sig);
        case (sig)
            0:       observe = 64'(u0_rd1);
            1:       observe = 64'(u0_rd2);
            2:       observe = 64'(u0_b1);
            3:       observe = 64'(u0_b2);
            4:       observe = 64'(u1_rd1);
            5:       observe = 64'(u1_b1);
            6:       observe = u2_rd1;
            7:       observe = u2_rd2;
            8:       observe = 64'(u2_b1);
            9:       observe = u3_rd1;
            10:      observe = u3_rd2;
            11:      observe = 64'(u3_b1);
            default: observe = 'x;
        endcase
    endfunction

    task automatic push(input string tag, input int unsigned sig, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        q.push_back(e);
    endtask

    // Sample the combinational outputs mid-cycle, score them, then take the edge.
    task automatic cyc();
        exp_t        e;
        logic [63:0] obs;
        @(negedge clk);
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.sig);
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        a1 = '0; a2 = '0; a3 = '0; sa = '0; di3 = '0; we3 = 0; se = 0; flush = 0;
        b_a1 = '0; b_a2 = '0; b_a3 = '0; b_sa = '0; b_di3 = '0; b_we3 = 0; b_se = 0; b_flush = 0;

        // Reset with a concurrent write: write is discarded
        reset = 1; we3 = 1; a3 = 5'd1; di3 = 32'd69;
        cyc();
        reset = 0; we3 = 0; a1 = 5'd1; a2 = 5'd1;
        push("rst_rd1", 0, 64'd0);
        push("rst_busy1", 2, 64'd0);
        push("rst_rd2", 1, 64'd0);
        push("rst_busy2", 3, 64'd0);
        push("rst_nb_rd1", 4, 64'd0);
        cyc();

        // Write and read back, with and without bypass
        we3 = 1; a3 = 5'd1; di3 = 32'd69;
        push("wr_bypass_rd1", 0, 64'd69);
        push("wr_bypass_busy1", 2, 64'd0);
        push("wr_nobypass_rd1", 4, 64'd0);
        cyc();
        we3 = 0;
        push("rdback_rd1", 0, 64'd69);
        push("rdback_nb_rd1", 4, 64'd69);
        cyc();

        // Zero register ignores writes and sets
        we3 = 1; a3 = 5'd0; di3 = 32'hDEADBEEF; se = 1; sa = 5'd0; a1 = 5'd0;
        push("zero_same_rd1", 0, 64'd0);
        push("zero_same_busy1", 2, 64'd0);
        push("zero_same_nb_rd1", 4, 64'd0);
        cyc();
        we3 = 0; se = 0;
        push("zero_after_rd1", 0, 64'd0);
        push("zero_after_busy1", 2, 64'd0);
        push("zero_after_nb_busy1", 5, 64'd0);
        cyc();
        push("zero_later_rd1", 0, 64'd0);
        push("zero_later_nb_rd1", 4, 64'd0);
        cyc();

        // Scoreboard lifecycle on register 5
        se = 1; sa = 5'd5; a2 = 5'd5; a1 = 5'd5;
        push("sb_preset_busy2", 3, 64'd0);
        cyc();
        se = 0;
        push("sb_set_busy2", 3, 64'd1);
        push("sb_set_nb_busy1", 5, 64'd1);
        cyc();
        we3 = 1; a3 = 5'd5; di3 = 32'h1234;
        push("sb_wb_busy2", 3, 64'd0);
        push("sb_wb_rd2", 1, 64'h1234);
        push("sb_wb_nb_busy1", 5, 64'd1);
        push("sb_wb_nb_rd1", 4, 64'd0);
        cyc();
        we3 = 0;
        push("sb_post_busy2", 3, 64'd0);
        push("sb_post_rd2", 1, 64'h1234);
        push("sb_post_nb_busy1", 5, 64'd0);
        push("sb_post_nb_rd1", 4, 64'h1234);
        cyc();

        // Set/clear collision on register 7
        se = 1; sa = 5'd7;
        cyc();
        se = 1; sa = 5'd7; we3 = 1; a3 = 5'd7; di3 = 32'd42; a1 = 5'd7; a2 = 5'd7;
        push("coll_same_rd1", 0, 64'd42);
        push("coll_same_busy1", 2, 64'd0);
        push("coll_same_nb_busy1", 5, 64'd1);
        push("coll_same_nb_rd1", 4, 64'd0);
        cyc();
        se = 0; we3 = 0;
        push("coll_after_busy1", 2, 64'd1);
        push("coll_after_busy2", 3, 64'd1);
        push("coll_after_rd1", 0, 64'd42);
        push("coll_after_rd2", 1, 64'd42);
        cyc();

        // Flush with concurrent set of register 9
        flush = 1; se = 1; sa = 5'd9; a1 = 5'd7; a2 = 5'd9;
        push("flush_pre_busy1", 2, 64'd1);
        push("flush_pre_busy2", 3, 64'd0);
        cyc();
        flush = 0; se = 0;
        push("flush_busy7", 2, 64'd0);
        push("flush_busy9", 3, 64'd1);
        push("flush_keep_rd1", 0, 64'd42);
        cyc();

        // Reset mid-operation overrides write, set and flush
        reset = 1; we3 = 1; a3 = 5'd3; di3 = 32'd77; se = 1; sa = 5'd3; flush = 1;
        cyc();
        reset = 0; we3 = 0; se = 0; flush = 0; a1 = 5'd3; a2 = 5'd9;
        push("rst2_rd1", 0, 64'd0);
        push("rst2_busy1", 2, 64'd0);
        push("rst2_busy2", 3, 64'd0);
        cyc();
        a1 = 5'd7; a2 = 5'd1;
        push("rst2_rd7", 0, 64'd0);
        push("rst2_rd1reg", 1, 64'd0);
        cyc();

        // 64-bit / 16-entry sweep
        b_we3 = 1; b_a3 = 4'd15; b_di3 = 64'hFFFF_FFFF_0000_0001; b_a1 = 4'd15;
        push("w64_bypass_rd1", 6, 64'hFFFF_FFFF_0000_0001);
        cyc();
        b_we3 = 0;
        push("w64_rdback_rd1", 6, 64'hFFFF_FFFF_0000_0001);
        cyc();
        b_we3 = 1; b_a3 = 4'd0; b_di3 = 64'hAB; b_a1 = 4'd0; b_a2 = 4'd15;
        push("w64_zr_same_rd1", 6, 64'd0);
        push("w64_nozr_same_rd1", 9, 64'hAB);
        cyc();
        b_we3 = 0;
        push("w64_zr_rd1", 6, 64'd0);
        push("w64_nozr_rd1", 9, 64'hAB);
        push("w64_nozr_rd2", 10, 64'hFFFF_FFFF_0000_0001);
        push("w64_zr_rd2", 7, 64'hFFFF_FFFF_0000_0001);
        cyc();
        b_se = 1; b_sa = 4'd0;
        cyc();
        b_se = 0;
        push("w64_zr_busy0", 8, 64'd0);
        push("w64_nozr_busy0", 11, 64'd1);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
